// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard decoder.
//   frame_state_t  - bit-level frame receiver states
//   BREAK_CODE     - break (key release) prefix byte
//   EXT_CODE       - extended-key prefix byte
package ps2_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned IDLE_CNT_W = 13;

    localparam logic [BYTE_W-1:0] BREAK_CODE = 8'hF0;
    localparam logic [BYTE_W-1:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 bit-level receiver.
// Synchronizes the raw PS/2 lines, frames start/8 data/parity/stop on psClk
// falling edges, checks odd parity and the stop bit, and aborts a stalled frame.
// Ports:
//   i_clk, i_rst      - system clock, synchronous active-high reset
//   i_ps_clk          - raw PS/2 clock pin (asynchronous)
//   i_ps_data         - raw PS/2 data pin (asynchronous)
//   o_byte            - received byte (valid with o_byte_valid_c)
//   o_byte_valid_c    - combinational pulse in the stop-bit edge cycle of a good frame
//   o_err_c           - combinational pulse on parity/stop error or timeout abort
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ps_clk,
    input  logic              i_ps_data,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_byte_valid_c,
    output logic              o_err_c
);

    frame_state_t r_state;
    frame_state_t w_next_state;

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic                  r_clk_prev;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-1:0]     r_shift;
    logic                  r_parity;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;

    logic w_ps_clk;
    logic w_ps_data;
    logic w_fall;
    logic w_timeout;

    assign w_ps_clk  = r_clk_sync[1];
    assign w_ps_data = r_data_sync[1];
    assign w_fall    = r_clk_prev & ~w_ps_clk;
    // An edge in the same cycle takes priority over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_idle_cnt == IDLE_CNT_W'(TIMEOUT_CYCLES));

    assign o_byte = r_shift;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and frame result pulses.
    always_comb begin
        w_next_state   = r_state;
        o_byte_valid_c = 1'b0;
        o_err_c        = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    // A high data bit here is not a start bit; ignore it.
                    if (!w_ps_data) begin
                        w_next_state = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == BIT_CNT_W'(7)) begin
                        w_next_state = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_next_state = ST_STOP;
                end
                ST_STOP: begin
                    w_next_state = ST_IDLE;
                    if (w_ps_data && odd_parity_ok(r_shift, r_parity)) begin
                        o_byte_valid_c = 1'b1;
                    end else begin
                        o_err_c = 1'b1;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_next_state = ST_IDLE;
            o_err_c      = 1'b1;
        end
    end

    // Synchronizers, edge history, shift register and idle counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps_clk};
            r_data_sync <= {r_data_sync[0], i_ps_data};
            r_clk_prev  <= w_ps_clk;

            if (w_fall || r_state == ST_IDLE || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_CNT_W'(1);
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_ps_data, r_shift[BYTE_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                    ST_PARITY: r_parity <= w_ps_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard scan-code decoder.
// Strips F0 (break) and E0 (extended) prefixes and reports each key event.
// Ports:
//   Clk, Reset  - 50 MHz system clock, synchronous active-high reset
//   psClk       - raw PS/2 clock pin
//   psData      - raw PS/2 data pin
//   keyCode     - last decoded scan code without prefixes
//   press       - 1 = make, 0 = break
//   extended    - 1 = E0-prefixed code
//   codeValid   - one-cycle pulse when keyCode/press/extended update
//   frameErr    - one-cycle pulse on parity, stop-bit or timeout error
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              psClk,
    input  logic              psData,
    output logic [BYTE_W-1:0] keyCode,
    output logic              press,
    output logic              extended,
    output logic              codeValid,
    output logic              frameErr
);

    logic [BYTE_W-1:0] w_byte;
    logic              w_byte_valid;
    logic              w_err;

    logic [BYTE_W-1:0] r_key_code;
    logic              r_press;
    logic              r_extended;
    logic              r_code_valid;
    logic              r_frame_err;
    logic              r_break_pend;
    logic              r_ext_pend;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .i_clk          (Clk),
        .i_rst          (Reset),
        .i_ps_clk       (psClk),
        .i_ps_data      (psData),
        .o_byte         (w_byte),
        .o_byte_valid_c (w_byte_valid),
        .o_err_c        (w_err)
    );

    // Prefix tracking and key event registers; prefixes span frames until used or an error.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_code   <= '0;
            r_press      <= 1'b0;
            r_extended   <= 1'b0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= w_err;
            if (w_err) begin
                r_break_pend <= 1'b0;
                r_ext_pend   <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == BREAK_CODE) begin
                    r_break_pend <= 1'b1;
                end else if (w_byte == EXT_CODE) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    r_key_code   <= w_byte;
                    r_press      <= ~r_break_pend;
                    r_extended   <= r_ext_pend;
                    r_code_valid <= 1'b1;
                    r_break_pend <= 1'b0;
                    r_ext_pend   <= 1'b0;
                end
            end
        end
    end

    assign keyCode   = r_key_code;
    assign press     = r_press;
    assign extended  = r_extended;
    assign codeValid = r_code_valid;
    assign frameErr  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of PS/2 frames with expected key state,
// a scoreboard of expected key events, and hand-written timeout/reset sequences.
module tb_ps2_key_decoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       psClk;
    logic       psData;
    logic [7:0] keyCode;
    logic       press;
    logic       extended;
    logic       codeValid;
    logic       frameErr;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .psClk     (psClk),
        .psData    (psData),
        .keyCode   (keyCode),
        .press     (press),
        .extended  (extended),
        .codeValid (codeValid),
        .frameErr  (frameErr)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic [7:0] key;
        logic       prs;
        logic       ext;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_key;
        logic       exp_press;
        logic       exp_ext;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    exp_t sb_q[$];
    exp_t sb_e;

    int checks   = 0;
    int failures = 0;
    int cv_cnt   = 0;
    int err_cnt  = 0;
    int cv0;
    int er0;
    int waited;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    // Scoreboard: every codeValid pulse must match the oldest expected event.
    always @(negedge Clk) begin
        if (!Reset && codeValid) begin
            cv_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual key=%h press=%b ext=%b required=none",
                         keyCode, press, extended);
            end else begin
                sb_e = sb_q.pop_front();
                if ({keyCode, press, extended} !== {sb_e.key, sb_e.prs, sb_e.ext}) begin
                    failures++;
                    $display("FAIL sb_event actual key=%h press=%b ext=%b required key=%h press=%b ext=%b",
                             keyCode, press, extended, sb_e.key, sb_e.prs, sb_e.ext);
                end
            end
        end
        if (!Reset && frameErr) err_cnt++;
    end

    // One PS/2 bit: data set while psClk high, then a falling edge, then release.
    task automatic send_bit(input logic b);
        @(negedge Clk);
        psData = b;
        repeat (8) @(negedge Clk);
        psClk = 1'b0;
        repeat (8) @(negedge Clk);
        psClk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        psData = 1'b1;
        repeat (20) @(negedge Clk);
    endtask

    task automatic push_exp(input logic [7:0] k, input logic p, input logic e);
        exp_t x;
        x.key = k;
        x.prs = p;
        x.ext = e;
        sb_q.push_back(x);
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[4]  = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0, 8'h74, 1'b1, 1'b1};
        vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h74, 1'b1, 1'b1};
        vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h74, 1'b1, 1'b1};
        vecs[7]  = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0, 8'h74, 1'b0, 1'b1};
        vecs[8]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h74, 1'b0, 1'b1};
        vecs[9]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0};
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29, 1'b1, 1'b0};
        vecs[11] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h29, 1'b1, 1'b0};
        vecs[12] = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0};
        vecs[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29, 1'b1, 1'b0};
        vecs[14] = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h29, 1'b1, 1'b0};
        vecs[15] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0};

        Reset  = 1'b1;
        psClk  = 1'b1;
        psData = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset_key", 0, int'(keyCode), 0);
        chk("reset_flags", 0, int'({press, extended, codeValid, frameErr}), 0);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Table-driven frames.
        for (int i = 0; i < NV; i++) begin
            cv0 = cv_cnt;
            er0 = err_cnt;
            if (vecs[i].exp_valid) push_exp(vecs[i].exp_key, vecs[i].exp_press, vecs[i].exp_ext);
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
            chk("valid_cnt", i, cv_cnt - cv0, int'(vecs[i].exp_valid));
            chk("err_cnt", i, err_cnt - er0, int'(vecs[i].exp_err));
            chk("keyCode", i, int'(keyCode), int'(vecs[i].exp_key));
            chk("press", i, int'(press), int'(vecs[i].exp_press));
            chk("extended", i, int'(extended), int'(vecs[i].exp_ext));
        end

        // Edge with data high while idle is not a start bit.
        cv0 = cv_cnt;
        er0 = err_cnt;
        send_bit(1'b1);
        push_exp(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("idle_hi_valid", 0, cv_cnt - cv0, 1);
        chk("idle_hi_err", 0, err_cnt - er0, 0);

        // Timeout: start bit plus 4 data bits, then bus goes quiet.
        er0 = err_cnt;
        cv0 = cv_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        psData = 1'b1;
        waited = 0;
        while (err_cnt == er0 && waited < 6000) begin
            @(negedge Clk);
            waited++;
        end
        chk("timeout_err", 0, err_cnt - er0, 1);
        chk("timeout_window", 0, int'(waited > 4900 && waited < 5100), 1);
        chk("timeout_no_valid", 0, cv_cnt - cv0, 0);
        repeat (10) @(negedge Clk);
        cv0 = cv_cnt;
        push_exp(8'h29, 1'b1, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("post_timeout_valid", 0, cv_cnt - cv0, 1);
        chk("post_timeout_key", 0, int'(keyCode), 8'h29);
        chk("post_timeout_press", 0, int'(press), 1);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midreset_key", 0, int'(keyCode), 0);
        chk("midreset_flags", 0, int'({press, extended, codeValid, frameErr}), 0);
        Reset  = 1'b0;
        psData = 1'b1;
        repeat (5) @(negedge Clk);
        cv0 = cv_cnt;
        er0 = err_cnt;
        push_exp(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("post_reset_valid", 0, cv_cnt - cv0, 1);
        chk("post_reset_err", 0, err_cnt - er0, 0);
        chk("post_reset_key", 0, int'(keyCode), 8'h1C);

        chk("sb_drained", 0, sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
